// File: rtl/gs_ntt_ctrl.sv
// Sequencer for an in-place DIF NTT built on a Gentleman-Sande butterfly: issues
// read/twiddle addresses per butterfly and the matching write-back LAT cycles later.
module gs_ntt_ctrl #(
  parameter int LOGN = 3,
  parameter int LAT  = 2,
  localparam int N   = 1 << LOGN,
  localparam int H   = N / 2,
  localparam int SW  = (LOGN > 1) ? $clog2(LOGN) : 1,
  localparam int KW  = (LOGN > 1) ? LOGN - 1 : 1,
  localparam int DW  = (LAT > 1) ? $clog2(LAT) : 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [SW-1:0]   stage_o,
  output logic            rd_en_o,
  output logic [LOGN-1:0] rd_addr_p_o,
  output logic [LOGN-1:0] rd_addr_q_o,
  output logic [LOGN-2:0] tw_addr_o,
  output logic            wr_en_o,
  output logic [LOGN-1:0] wr_addr_p_o,
  output logic [LOGN-1:0] wr_addr_q_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [LOGN-1:0] p;
    logic [LOGN-1:0] q;
    logic [LOGN-2:0] tw;
  } addr_t;

  function automatic addr_t addr_of(input int k, input int s);
    int    h, j, p;
    addr_t a;
    h    = N >> (s + 1);
    j    = k & (h - 1);
    p    = ((k >> (LOGN - 1 - s)) << (LOGN - s)) | j;
    a.p  = LOGN'(p);
    a.q  = LOGN'(p | h);
    a.tw = (LOGN-1)'(j << s);
    return a;
  endfunction

  state_t          state_q;
  logic [KW-1:0]   k_q;
  logic [SW-1:0]   s_q;
  logic [DW-1:0]   dcnt_q;
  logic            busy_q, done_q, rd_en_q;
  addr_t           rd_q, rd_d;

  logic [LAT-1:0]            vld_pipe_q;
  logic [LAT-1:0][LOGN-1:0]  wp_pipe_q, wq_pipe_q;

  // Address of the read that will be presented in the next cycle, if any.
  always_comb begin
    rd_d = addr_of(0, 0);
    if (state_q == RUN)        rd_d = addr_of(int'(k_q) + 1, int'(s_q));
    else if (state_q == DRAIN) rd_d = addr_of(0, int'(s_q) + 1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= RUN;
            k_q     <= '0;
            s_q     <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            rd_q    <= rd_d;
          end
        end
        RUN: begin
          if (k_q == KW'(H - 1)) begin
            state_q <= DRAIN;
            dcnt_q  <= '0;
            rd_en_q <= 1'b0;
          end else begin
            k_q  <= k_q + KW'(1);
            rd_q <= rd_d;
          end
        end
        DRAIN: begin
          // Hold off the next stage until its last write-back has landed.
          if (dcnt_q == DW'(LAT - 1)) begin
            if (s_q != SW'(LOGN - 1)) begin
              state_q <= RUN;
              s_q     <= s_q + SW'(1);
              k_q     <= '0;
              rd_en_q <= 1'b1;
              rd_q    <= rd_d;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_pipe_q <= '0;
      wp_pipe_q  <= '0;
      wq_pipe_q  <= '0;
    end else begin
      vld_pipe_q[0] <= rd_en_q;
      wp_pipe_q[0]  <= rd_q.p;
      wq_pipe_q[0]  <= rd_q.q;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        wp_pipe_q[i]  <= wp_pipe_q[i-1];
        wq_pipe_q[i]  <= wq_pipe_q[i-1];
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign stage_o     = s_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_p_o = rd_q.p;
  assign rd_addr_q_o = rd_q.q;
  assign tw_addr_o   = rd_q.tw;
  assign wr_en_o     = vld_pipe_q[LAT-1];
  assign wr_addr_p_o = wp_pipe_q[LAT-1];
  assign wr_addr_q_o = wq_pipe_q[LAT-1];

endmodule

// File: tb/tb_gs_ntt_ctrl.sv
// Bench for gs_ntt_ctrl: two instances (LOGN=3/LAT=2 and LOGN=4/LAT=3) checked every
// cycle against a schedule-based model, plus literal expectations for known traces.
module tb_gs_ntt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, st_a, rst_b, st_b;

  logic       a_busy, a_done, a_rd, a_wr;
  logic [1:0] a_stage, a_tw;
  logic [2:0] a_rp, a_rq, a_wp, a_wq;

  logic       b_busy, b_done, b_rd, b_wr;
  logic [1:0] b_stage;
  logic [2:0] b_tw;
  logic [3:0] b_rp, b_rq, b_wp, b_wq;

  gs_ntt_ctrl #(.LOGN(3), .LAT(2)) u_a (
    .clk_i(clk), .reset_i(rst_a), .start_i(st_a),
    .busy_o(a_busy), .done_o(a_done), .stage_o(a_stage),
    .rd_en_o(a_rd), .rd_addr_p_o(a_rp), .rd_addr_q_o(a_rq), .tw_addr_o(a_tw),
    .wr_en_o(a_wr), .wr_addr_p_o(a_wp), .wr_addr_q_o(a_wq)
  );

  gs_ntt_ctrl #(.LOGN(4), .LAT(3)) u_b (
    .clk_i(clk), .reset_i(rst_b), .start_i(st_b),
    .busy_o(b_busy), .done_o(b_done), .stage_o(b_stage),
    .rd_en_o(b_rd), .rd_addr_p_o(b_rp), .rd_addr_q_o(b_rq), .tw_addr_o(b_tw),
    .wr_en_o(b_wr), .wr_addr_p_o(b_wp), .wr_addr_q_o(b_wq)
  );

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    bit busy, done, rd, wr;
    int stage, rp, rq, tw, wp, wq;
  } ob_t;

  function automatic int lgn(int i); return (i == 0) ? 3 : 4; endfunction
  function automatic int lat(int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int per(int i); return (1 << (lgn(i) - 1)) + lat(i); endfunction
  function automatic int tdone(int i); return lgn(i) * per(i) + 1; endfunction

  // Butterfly k of stage s pairs p with p+h inside group k/h.
  function automatic void bfly(input int lg, input int s, input int k,
                               output int p, output int q, output int tw);
    int h, j;
    h  = (1 << lg) >> (s + 1);
    j  = k % h;
    p  = (k / h) * 2 * h + j;
    q  = p + h;
    tw = (j << s) % (1 << (lg - 1));
  endfunction

  // Expected outputs r cycles into a transform (r=1 is the first read cycle).
  function automatic ob_t model(int i, int r);
    ob_t o;
    int  lg, lt, h, rs, rw, d0, d1, d2;
    o  = '{default: 0};
    lg = lgn(i); lt = lat(i); h = 1 << (lg - 1);
    o.busy = (r >= 1) && (r < tdone(i));
    o.done = (r == tdone(i));
    if (o.busy) o.stage = (r - 1) / per(i);
    for (int s = 0; s < lg; s++) begin
      rs = r - 1 - s * per(i);
      rw = rs - lt;
      if (rs >= 0 && rs < h) begin
        o.rd = 1'b1;
        bfly(lg, s, rs, o.rp, o.rq, o.tw);
      end
      if (rw >= 0 && rw < h) begin
        o.wr = 1'b1;
        bfly(lg, s, rw, o.wp, o.wq, d2);
      end
    end
    d0 = 0; d1 = d0;
    return o;
  endfunction

  function automatic ob_t dut_ob(int i);
    ob_t o;
    if (i == 0) begin
      o.busy = a_busy; o.done = a_done; o.rd = a_rd; o.wr = a_wr;
      o.stage = int'(a_stage); o.rp = int'(a_rp); o.rq = int'(a_rq);
      o.tw = int'(a_tw); o.wp = int'(a_wp); o.wq = int'(a_wq);
    end else begin
      o.busy = b_busy; o.done = b_done; o.rd = b_rd; o.wr = b_wr;
      o.stage = int'(b_stage); o.rp = int'(b_rp); o.rq = int'(b_rq);
      o.tw = int'(b_tw); o.wp = int'(b_wp); o.wq = int'(b_wq);
    end
    return o;
  endfunction

  task automatic chk(string nm, int i, int g, int e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s inst%0d edge%0d: got %0d expected %0d", nm, i, edge_n, g, e);
    end
  endtask

  task automatic lit(string nm, int g, int e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, g, e);
    end
  endtask

  // Model state: active transform, count of edges at its first cycle, post-reset flag.
  int act[2] = '{0, 0};
  int es[2]  = '{0, 0};
  int zs[2]  = '{1, 1};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int  r;
      bit  rs_i, st_i, idle;
      ob_t e, g;
      r = (act[i] != 0) ? edge_n - es[i] + 1 : 0;
      if (edge_n >= 1) begin
        e = (act[i] != 0) ? model(i, r) : '{default: 0};
        g = dut_ob(i);
        chk("busy", i, int'(g.busy), int'(e.busy));
        chk("done", i, int'(g.done), int'(e.done));
        chk("rd_en", i, int'(g.rd), int'(e.rd));
        chk("wr_en", i, int'(g.wr), int'(e.wr));
        if (e.rd) begin
          chk("rd_p", i, g.rp, e.rp);
          chk("rd_q", i, g.rq, e.rq);
          chk("tw", i, g.tw, e.tw);
        end
        if (e.wr) begin
          chk("wr_p", i, g.wp, e.wp);
          chk("wr_q", i, g.wq, e.wq);
        end
        if (e.busy) chk("stage", i, g.stage, e.stage);
        if (zs[i] != 0) begin
          chk("z_stage", i, g.stage, 0);
          chk("z_rd_p", i, g.rp, 0);
          chk("z_rd_q", i, g.rq, 0);
          chk("z_tw", i, g.tw, 0);
          chk("z_wr_p", i, g.wp, 0);
          chk("z_wr_q", i, g.wq, 0);
        end
      end
      rs_i = (i == 0) ? rst_a : rst_b;
      st_i = (i == 0) ? st_a : st_b;
      idle = (act[i] == 0) || (r > tdone(i));
      if (rs_i) begin
        act[i] = 0; zs[i] = 1;
      end else if (idle && st_i) begin
        act[i] = 1; es[i] = edge_n + 1; zs[i] = 0;
      end
    end
  end

  int lp[12]  = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int lq[12]  = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int ltw[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

  function automatic int ridx(int c);
    int s, k;
    if (c < 1) return -1;
    s = (c - 1) / 6;
    k = (c - 1) % 6;
    if (s > 2 || k > 3) return -1;
    return s * 4 + k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Default-size transform from a single start pulse, against literal tables.
  task automatic scn1();
    int nw, ix, iw;
    nw = 0;
    st_a = 1'b1;
    step();
    st_a = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      ix = ridx(c);
      iw = ridx(c - 2);
      lit("s1_rd_en", int'(a_rd), int'(ix >= 0));
      if (ix >= 0) begin
        lit("s1_rd_p", int'(a_rp), lp[ix]);
        lit("s1_rd_q", int'(a_rq), lq[ix]);
        lit("s1_tw", int'(a_tw), ltw[ix]);
      end
      lit("s1_wr_en", int'(a_wr), int'(iw >= 0));
      if (iw >= 0) begin
        lit("s1_wr_p", int'(a_wp), lp[iw]);
        lit("s1_wr_q", int'(a_wq), lq[iw]);
      end
      if (a_wr) nw++;
      lit("s1_done", int'(a_done), int'(c == 19));
      lit("s1_busy", int'(a_busy), int'(c <= 18));
      step();
    end
    lit("s1_nwrites", nw, 12);
  endtask

  initial begin
    rst_a = 1'b1; st_a = 1'b0; rst_b = 1'b1; st_b = 1'b0;
    repeat (3) step();
    @(negedge clk);
    lit("rst_busy", int'(a_busy), 0);
    lit("rst_wr", int'(a_wr), 0);
    rst_a = 1'b0; rst_b = 1'b0;
    step();

    rst_a = 1'b1; st_a = 1'b1;
    step();
    rst_a = 1'b0; st_a = 1'b0;
    @(negedge clk);
    lit("rs_start_busy", int'(a_busy), 0);
    lit("rs_start_rd", int'(a_rd), 0);
    step();

    scn1();

    st_a = 1'b1;
    step();
    st_a = 1'b0;
    repeat (8) step();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    for (int c = 10; c <= 21; c++) begin
      @(negedge clk);
      lit("mr_busy", int'(a_busy), 0);
      lit("mr_rd", int'(a_rd), 0);
      lit("mr_wr", int'(a_wr), 0);
      lit("mr_addr", int'(a_rp) + int'(a_rq) + int'(a_wp) + int'(a_wq) + int'(a_tw), 0);
      step();
    end

    scn1();

    st_a = 1'b1;
    step();
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      lit("held_done", int'(a_done), int'(c == 19 || c == 39));
      step();
    end
    st_a = 1'b0;
    repeat (25) step();

    st_b = 1'b1;
    step();
    st_b = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      if (c == 1 || c == 8 || c == 39) begin
        lit("b_rd_en", int'(b_rd), 1);
        lit("b_rd_p", int'(b_rp), (c == 1) ? 0 : (c == 8) ? 7 : 10);
        lit("b_rd_q", int'(b_rq), (c == 1) ? 8 : (c == 8) ? 15 : 11);
        lit("b_tw", int'(b_tw), (c == 8) ? 7 : 0);
      end
      lit("b_done", int'(b_done), int'(c == 45));
      step();
    end

    for (int n = 0; n < 3000; n++) begin
      st_a  = ($urandom_range(3) == 0);
      st_b  = ($urandom_range(3) == 0);
      rst_a = ($urandom_range(149) == 0);
      rst_b = ($urandom_range(149) == 0);
      step();
    end
    st_a = 1'b0; st_b = 1'b0;
    repeat (60) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
